// File: rtl/add_result_misr.sv
// add_result_misr: signature stage behind the FF-bounded adder speed tests.
//
// Every accepted sum word is folded down to SIG_BITS and shifted into a MISR.
// A frame is FRAME_LEN accepted samples long. The signature register plus the
// single sig_bit pin keep the adder result observable, so synthesis cannot
// optimise the adder away. s_data goes straight into the fold with no logic in
// front of it, which keeps the adder-to-register path purely FF-to-FF.
//
// Optional feature macro: ADD_RESULT_MISR_CHECK_EN
//   When it is defined, the module gains parameter EXPECT_SIG and output
//   match. match is set at the end of a frame when the final signature
//   equals EXPECT_SIG.
//
// Ports:
//   clk        in   1         clock, rising edge
//   reset_n    in   1         asynchronous active-low reset
//   cke        in   1         clock enable; low freezes all state
//   s_data     in   C_BITS    sum word from the adder stage
//   s_valid    in   1         s_data valid this cycle
//   start      in   1         begin a new frame (ignored while busy)
//   busy       out  1         frame in progress
//   done       out  1         one-cycle pulse: frame complete
//   signature  out  SIG_BITS  MISR value; stable from done until next start
//   sig_bit    out  1         registered XOR-reduction of signature
//   match      out  1         (CHECK_EN only) final signature == EXPECT_SIG

module add_result_misr #(
  parameter int unsigned          C_BITS    = 65,
  parameter int unsigned          SIG_BITS  = 32,
  parameter logic [SIG_BITS-1:0]  POLY      = SIG_BITS'(32'h04C1_1DB7),
  parameter logic [SIG_BITS-1:0]  SEED      = '1,
  parameter int unsigned          FRAME_LEN = 1024
`ifdef ADD_RESULT_MISR_CHECK_EN
  ,
  parameter logic [SIG_BITS-1:0]  EXPECT_SIG = '0
`endif
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cke,
  input  logic [C_BITS-1:0]   s_data,
  input  logic                s_valid,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [SIG_BITS-1:0] signature,
  output logic                sig_bit
`ifdef ADD_RESULT_MISR_CHECK_EN
  ,
  output logic                match
`endif
);

  localparam int unsigned NCHUNK   = (C_BITS + SIG_BITS - 1) / SIG_BITS;
  localparam int unsigned PAD_BITS = NCHUNK * SIG_BITS;
  localparam int unsigned CNT_BITS = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(FRAME_LEN - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [CNT_BITS-1:0] count_q, count_d;
  logic [SIG_BITS-1:0] sig_q, sig_d;
  logic                done_q, done_d;
  logic                sig_bit_q;

  logic [PAD_BITS-1:0] padded;
  logic [SIG_BITS-1:0] fold;
  logic [SIG_BITS-1:0] sig_step;

  // Zero-pad the sum to whole chunks and XOR the chunks together.
  always_comb begin
    padded = PAD_BITS'(s_data);
    fold   = '0;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      fold = fold ^ padded[i*SIG_BITS +: SIG_BITS];
    end
  end

  assign sig_step = {sig_q[SIG_BITS-2:0], 1'b0}
                  ^ (sig_q[SIG_BITS-1] ? POLY : '0)
                  ^ fold;

`ifdef ADD_RESULT_MISR_CHECK_EN
  logic match_q, match_d;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    sig_d   = sig_q;
    done_d  = 1'b0;
`ifdef ADD_RESULT_MISR_CHECK_EN
    match_d = match_q;
`endif
    case (state_q)
      RUN: begin
        // start is deliberately ignored here: a frame always runs to completion.
        if (s_valid) begin
          sig_d   = sig_step;
          count_d = count_q + CNT_BITS'(1);
          if (count_q == LAST_CNT) begin
            state_d = DONE;
            done_d  = 1'b1;
`ifdef ADD_RESULT_MISR_CHECK_EN
            // Compare the value being written so match is valid alongside done.
            match_d = (sig_step == EXPECT_SIG);
`endif
          end
        end
      end
      default: begin
        // IDLE and DONE both accept start; DONE otherwise falls back to IDLE.
        if (start) begin
          state_d = RUN;
          sig_d   = SEED;
          count_d = '0;
`ifdef ADD_RESULT_MISR_CHECK_EN
          match_d = 1'b0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      sig_q     <= SEED;
      done_q    <= 1'b0;
      sig_bit_q <= ^SEED;
    end else if (cke) begin
      state_q   <= state_d;
      count_q   <= count_d;
      sig_q     <= sig_d;
      done_q    <= done_d;
      sig_bit_q <= ^sig_q;
    end
  end

`ifdef ADD_RESULT_MISR_CHECK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      match_q <= 1'b0;
    end else if (cke) begin
      match_q <= match_d;
    end
  end

  assign match = match_q;
`endif

  assign busy      = (state_q == RUN);
  assign done      = done_q;
  assign signature = sig_q;
  assign sig_bit   = sig_bit_q;

endmodule

// File: tb/tb_add_result_misr.sv
module tb_add_result_misr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, cke;

  // DUT a: C_BITS=8, SEED=FF, FRAME_LEN=1
  logic       a_start, a_valid, a_busy, a_done, a_sig_bit;
  logic [7:0] a_data, a_sig;
  // DUT b: C_BITS=9, SEED=00, FRAME_LEN=1
  logic       b_start, b_valid, b_busy, b_done, b_sig_bit;
  logic [8:0] b_data;
  logic [7:0] b_sig;
  // DUT c: C_BITS=16 (two chunks), SEED=00, FRAME_LEN=4
  logic        c_start, c_valid, c_busy, c_done, c_sig_bit;
  logic [15:0] c_data;
  logic [7:0]  c_sig;

`ifdef ADD_RESULT_MISR_CHECK_EN
  logic a_match, b_match, c_match;

  add_result_misr #(.C_BITS(8), .SIG_BITS(8), .POLY(8'h07), .SEED(8'hFF), .FRAME_LEN(1),
                    .EXPECT_SIG(8'hF9)) u_a (
    .clk(clk), .reset_n(reset_n), .cke(cke), .s_data(a_data), .s_valid(a_valid),
    .start(a_start), .busy(a_busy), .done(a_done), .signature(a_sig), .sig_bit(a_sig_bit),
    .match(a_match));
  add_result_misr #(.C_BITS(9), .SIG_BITS(8), .POLY(8'h07), .SEED(8'h00), .FRAME_LEN(1),
                    .EXPECT_SIG(8'h00)) u_b (
    .clk(clk), .reset_n(reset_n), .cke(cke), .s_data(b_data), .s_valid(b_valid),
    .start(b_start), .busy(b_busy), .done(b_done), .signature(b_sig), .sig_bit(b_sig_bit),
    .match(b_match));
  add_result_misr #(.C_BITS(16), .SIG_BITS(8), .POLY(8'h07), .SEED(8'h00), .FRAME_LEN(4),
                    .EXPECT_SIG(8'h00)) u_c (
    .clk(clk), .reset_n(reset_n), .cke(cke), .s_data(c_data), .s_valid(c_valid),
    .start(c_start), .busy(c_busy), .done(c_done), .signature(c_sig), .sig_bit(c_sig_bit),
    .match(c_match));
`else
  add_result_misr #(.C_BITS(8), .SIG_BITS(8), .POLY(8'h07), .SEED(8'hFF), .FRAME_LEN(1)) u_a (
    .clk(clk), .reset_n(reset_n), .cke(cke), .s_data(a_data), .s_valid(a_valid),
    .start(a_start), .busy(a_busy), .done(a_done), .signature(a_sig), .sig_bit(a_sig_bit));
  add_result_misr #(.C_BITS(9), .SIG_BITS(8), .POLY(8'h07), .SEED(8'h00), .FRAME_LEN(1)) u_b (
    .clk(clk), .reset_n(reset_n), .cke(cke), .s_data(b_data), .s_valid(b_valid),
    .start(b_start), .busy(b_busy), .done(b_done), .signature(b_sig), .sig_bit(b_sig_bit));
  add_result_misr #(.C_BITS(16), .SIG_BITS(8), .POLY(8'h07), .SEED(8'h00), .FRAME_LEN(4)) u_c (
    .clk(clk), .reset_n(reset_n), .cke(cke), .s_data(c_data), .s_valid(c_valid),
    .start(c_start), .busy(c_busy), .done(c_done), .signature(c_sig), .sig_bit(c_sig_bit));
`endif

  int checks = 0;
  int errors = 0;

  // Frame for DUT c: folds 26, FF, 00, 81 -> signatures 26, B3, 61, 43
  logic [15:0] smp  [4] = '{16'h1234, 16'h00FF, 16'hA5A5, 16'h8001};
  logic [7:0]  exp3 [4] = '{8'h26, 8'hB3, 8'h61, 8'h43};
  // Second frame: folds 03, 00, 80, 01 -> signatures 03, 06, 8C, 1E
  logic [15:0] smp2 [4] = '{16'h0102, 16'hFFFF, 16'h0080, 16'h0001};
  logic [7:0]  exp5 [4] = '{8'h03, 8'h06, 8'h8C, 8'h1E};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; cke = 1'b1;
    a_start = 0; a_valid = 0; a_data = '0;
    b_start = 0; b_valid = 0; b_data = '0;
    c_start = 0; c_valid = 0; c_data = '0;
    step(); step();
    reset_n = 1'b1;
    step();

    // Reset state
    check("rst a sig", 32'(a_sig), 32'hFF);
    check("rst a busy", 32'(a_busy), 0);
    check("rst a done", 32'(a_done), 0);
    check("rst c sig", 32'(c_sig), 32'h00);
    check("rst b sig_bit", 32'(b_sig_bit), 0);

    // Test 1: valid outside RUN ignored, then one-sample frame from FF
    a_valid = 1; a_data = 8'h55; step();
    check("t1 idle valid sig", 32'(a_sig), 32'hFF);
    check("t1 idle valid busy", 32'(a_busy), 0);
    a_valid = 0; a_start = 1; step();
    check("t1 busy", 32'(a_busy), 1);
    check("t1 sig seed", 32'(a_sig), 32'hFF);
    a_start = 0; a_valid = 1; a_data = 8'h00; step();
    check("t1 sig", 32'(a_sig), 32'hF9);
    check("t1 done", 32'(a_done), 1);
    check("t1 busy end", 32'(a_busy), 0);
`ifdef ADD_RESULT_MISR_CHECK_EN
    check("t1 match", 32'(a_match), 1);
`endif
    a_valid = 0; step();
    check("t1 done gone", 32'(a_done), 0);
    check("t1 sig held", 32'(a_sig), 32'hF9);
    check("t1 sig_bit", 32'(a_sig_bit), 0);

    // Test 2: fold of a 9-bit word
    b_start = 1; step();
    b_start = 0; b_valid = 1; b_data = 9'h100; step();
    check("t2 sig", 32'(b_sig), 32'h01);
    check("t2 done", 32'(b_done), 1);
    check("t2 sig_bit lag", 32'(b_sig_bit), 0);
    b_valid = 0; step();
    check("t2 sig_bit", 32'(b_sig_bit), 1);
    check("t2 done gone", 32'(b_done), 0);

    // Test 3: toggling valid, done only after the 4th sample
    c_start = 1; step();
    check("t3 busy", 32'(c_busy), 1);
    c_start = 0;
    for (int i = 0; i < 4; i++) begin
      c_valid = 1; c_data = smp[i]; step();
      check($sformatf("t3 sig %0d", i), 32'(c_sig), 32'(exp3[i]));
      check($sformatf("t3 done %0d", i), 32'(c_done), (i == 3) ? 1 : 0);
      check($sformatf("t3 busy %0d", i), 32'(c_busy), (i == 3) ? 0 : 1);
      c_valid = 0; c_data = 16'hFFFF; step();
      check($sformatf("t3 gap sig %0d", i), 32'(c_sig), 32'(exp3[i]));
      check($sformatf("t3 gap done %0d", i), 32'(c_done), 0);
    end

    // Test 4: cke stall mid-frame and during done
    c_start = 1; step();
    c_start = 0; c_valid = 1; c_data = smp[0]; step();
    check("t4 sig0", 32'(c_sig), 32'h26);
    cke = 0; c_data = smp[1];
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("t4 stall sig %0d", i), 32'(c_sig), 32'h26);
      check($sformatf("t4 stall busy %0d", i), 32'(c_busy), 1);
    end
    cke = 1; step();
    check("t4 sig1", 32'(c_sig), 32'hB3);
    c_data = smp[2]; step();
    check("t4 sig2", 32'(c_sig), 32'h61);
    check("t4 no early done", 32'(c_done), 0);
    c_data = smp[3]; step();
    check("t4 sig3", 32'(c_sig), 32'h43);
    check("t4 done", 32'(c_done), 1);
    c_valid = 0; cke = 0; step(); step();
    check("t4 done frozen", 32'(c_done), 1);
    check("t4 sig frozen", 32'(c_sig), 32'h43);
    cke = 1; step();
    check("t4 done gone", 32'(c_done), 0);
    check("t4 idle", 32'(c_busy), 0);

    // Test 5: start in RUN ignored; start during done honoured
    c_start = 1; step();
    c_start = 0; c_valid = 1; c_data = smp[0]; step();
    c_data = smp[1]; step();
    c_start = 1; c_data = smp[2]; step();
    check("t5 start ignored sig", 32'(c_sig), 32'h61);
    check("t5 start ignored busy", 32'(c_busy), 1);
    c_start = 0; c_data = smp[3]; step();
    check("t5 sig", 32'(c_sig), 32'h43);
    check("t5 done", 32'(c_done), 1);
    c_start = 1; c_valid = 0; step();
    check("t5 restart busy", 32'(c_busy), 1);
    check("t5 restart sig", 32'(c_sig), 32'h00);
    check("t5 restart done", 32'(c_done), 0);
    c_start = 0; c_valid = 1;
    for (int i = 0; i < 4; i++) begin
      c_data = smp2[i]; step();
      check($sformatf("t5 f2 sig %0d", i), 32'(c_sig), 32'(exp5[i]));
      check($sformatf("t5 f2 done %0d", i), 32'(c_done), (i == 3) ? 1 : 0);
    end
    c_valid = 0; step();

    // Test 6: asynchronous reset mid-frame
    c_start = 1; step();
    c_start = 0; c_valid = 1; c_data = smp[0]; step();
    c_data = smp[1]; step();
    check("t6 pre sig", 32'(c_sig), 32'hB3);
    c_valid = 0;
    #2 reset_n = 1'b0;
    #1;
    check("t6 c busy", 32'(c_busy), 0);
    check("t6 c sig", 32'(c_sig), 32'h00);
    check("t6 a sig", 32'(a_sig), 32'hFF);
    check("t6 b sig_bit", 32'(b_sig_bit), 0);
`ifdef ADD_RESULT_MISR_CHECK_EN
    check("t6 a match", 32'(a_match), 0);
`endif
    #3 reset_n = 1'b1;
    step();
    check("t6 after busy", 32'(c_busy), 0);
    check("t6 after sig", 32'(c_sig), 32'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
